// File: rtl/mat_solve_sequencer.sv
// mat_solve_sequencer: memory-bus sequencer for a Gauss-Seidel Ax=Y solver.
// Issues GET_N / READ_Y / READ_A / READ_X / WRITE_X on the opcode/i/j bus,
// tags each returned word for the MAC datapath, and writes every row result
// back in place as X[row]. After ITERS sweeps it parks in DONE with fin high.
module mat_solve_sequencer #(
  parameter int DW    = 20,
  parameter int AW    = 20,
  parameter int NW    = 10,
  parameter int MAX_N = 32,
  parameter int ITERS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] in_data,
  output logic [2:0]    opcode,
  output logic [AW-1:0] i,
  output logic [AW-1:0] j,
  output logic [DW-1:0] out_data,
  output logic          fin,
  output logic          busy,
  output logic          dp_clr,
  output logic          dp_y_valid,
  output logic          dp_a_valid,
  output logic          dp_x_valid,
  output logic          dp_diag,
  output logic          dp_last,
  output logic [DW-1:0] dp_data,
  input  logic          dp_res_valid,
  input  logic [DW-1:0] dp_res
);

  localparam int SW = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic [2:0] OP_GETN  = 3'b000;
  localparam logic [2:0] OP_RDY   = 3'b001;
  localparam logic [2:0] OP_RDA   = 3'b010;
  localparam logic [2:0] OP_RDX   = 3'b011;
  localparam logic [2:0] OP_WRX   = 3'b100;
  localparam logic [2:0] OP_NOP   = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE, S_GETN, S_LATN, S_ROWY, S_RA, S_RX, S_WAIT, S_WR, S_DONE
  } state_t;

  // Per-word tag that travels one cycle behind the opcode so it lines up
  // with the memory's read data.
  typedef struct packed {
    logic y;
    logic a;
    logic x;
    logic diag;
    logic last;
  } dp_tag_t;

  state_t          state, state_d;
  logic [NW-1:0]   n_q, n_d, row, row_d, col, col_d, n_clamp;
  logic [SW-1:0]   sweep, sweep_d;
  logic [DW-1:0]   out_d;
  logic [2:0]      op_d;
  logic [AW-1:0]   i_d, j_d;
  logic            clr_d;
  dp_tag_t         tag_d, tag_q, tag_dp;

  // Oversized matrices are solved on their top-left MAX_N x MAX_N block.
  assign n_clamp = (in_data[NW-1:0] > NW'(MAX_N)) ? NW'(MAX_N) : in_data[NW-1:0];

  // Next state and loop counters; one bus operation per state.
  always_comb begin
    state_d = state;
    n_d     = n_q;
    row_d   = row;
    col_d   = col;
    sweep_d = sweep;
    out_d   = out_data;
    case (state)
      S_IDLE: if (start) state_d = S_GETN;
      S_GETN: state_d = S_LATN;
      S_LATN: begin
        n_d = n_clamp;
        if (n_clamp == '0) begin
          state_d = S_DONE;
        end else begin
          row_d   = '0;
          sweep_d = '0;
          state_d = S_ROWY;
        end
      end
      S_ROWY: begin
        col_d   = '0;
        state_d = S_RA;
      end
      S_RA: state_d = S_RX;
      S_RX: begin
        if (col == n_q - NW'(1)) begin
          state_d = S_WAIT;
        end else begin
          col_d   = col + NW'(1);
          state_d = S_RA;
        end
      end
      // Result pulses outside WAIT are deliberately dropped.
      S_WAIT: begin
        if (dp_res_valid) begin
          out_d   = dp_res;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (row != n_q - NW'(1)) begin
          row_d   = row + NW'(1);
          state_d = S_ROWY;
        end else if (sweep != SW'(ITERS - 1)) begin
          sweep_d = sweep + SW'(1);
          row_d   = '0;
          state_d = S_ROWY;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: if (start) state_d = S_GETN;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus word for the state being entered, so opcode/i/j come straight off flops.
  always_comb begin
    op_d  = OP_NOP;
    i_d   = '0;
    j_d   = '0;
    clr_d = 1'b0;
    tag_d = '0;
    case (state_d)
      S_GETN: op_d = OP_GETN;
      S_ROWY: begin
        op_d    = OP_RDY;
        i_d     = AW'(row_d);
        clr_d   = 1'b1;
        tag_d.y = 1'b1;
      end
      S_RA: begin
        op_d       = OP_RDA;
        i_d        = AW'(row_d);
        j_d        = AW'(col_d);
        tag_d.a    = 1'b1;
        tag_d.diag = (col_d == row_d);
      end
      S_RX: begin
        op_d       = OP_RDX;
        i_d        = AW'(col_d);
        tag_d.x    = 1'b1;
        tag_d.diag = (col_d == row_d);
        tag_d.last = (col_d == n_q - NW'(1));
      end
      S_WR: begin
        op_d = OP_WRX;
        i_d  = AW'(row_d);
      end
      default: ;
    endcase
  end

  // State and counter registers; reset aborts any sweep with no write issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      n_q   <= '0;
      row   <= '0;
      col   <= '0;
      sweep <= '0;
    end else begin
      state <= state_d;
      n_q   <= n_d;
      row   <= row_d;
      col   <= col_d;
      sweep <= sweep_d;
    end
  end

  // Registered bus outputs and the issue-stage tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode   <= OP_NOP;
      i        <= '0;
      j        <= '0;
      out_data <= '0;
      dp_clr   <= 1'b0;
      tag_q    <= '0;
    end else begin
      opcode   <= op_d;
      i        <= i_d;
      j        <= j_d;
      out_data <= out_d;
      dp_clr   <= clr_d;
      tag_q    <= tag_d;
    end
  end

  // Delay the tag one more cycle so it qualifies the returning in_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tag_dp <= '0;
    else     tag_dp <= tag_q;
  end

  assign dp_y_valid = tag_dp.y;
  assign dp_a_valid = tag_dp.a;
  assign dp_x_valid = tag_dp.x;
  assign dp_diag    = tag_dp.diag;
  assign dp_last    = tag_dp.last;
  assign dp_data    = in_data;

  assign fin  = (state == S_DONE);
  assign busy = (state != S_IDLE) && (state != S_DONE);

endmodule
